// File: rtl/mapped_timer_pkg.sv
// Shared register offsets, CTRL bit positions and reset constants for the
// memory-mapped timer bank.
package mapped_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_MAX    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_ONESHOT   = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam logic [15:0] MAX_RESET = 16'hFFFF;

endpackage

// File: rtl/mapped_timer_ch.sv
// One timer channel: CTRL/COUNT/MAX/STATUS registers, prescaler and
// up-counter with reload compare.
module mapped_timer_ch
  import mapped_timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   reg_sel,
  input  logic [15:0]  wr_data,
  input  logic         wr_en,
  output logic [15:0]  rd_data,
  output logic         irq
);

  logic               en;
  logic               oneshot;
  logic               irq_en;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic [15:0]        count;
  logic [15:0]        max_val;
  logic               flag;

  logic wr_ctrl, wr_count, wr_max, wr_status;
  logic tick, wrap;

  assign wr_ctrl   = wr_en && (reg_sel == REG_CTRL);
  assign wr_count  = wr_en && (reg_sel == REG_COUNT);
  assign wr_max    = wr_en && (reg_sel == REG_MAX);
  assign wr_status = wr_en && (reg_sel == REG_STATUS);

  assign tick = en && (presc_cnt == presc);
  // A COUNT write in the same cycle swallows the tick's reload and flag.
  assign wrap = tick && (count == max_val) && !wr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      oneshot   <= 1'b0;
      irq_en    <= 1'b0;
      presc     <= '0;
      presc_cnt <= '0;
      count     <= '0;
      max_val   <= MAX_RESET;
      flag      <= 1'b0;
    end else begin
      if (!en || tick || wr_count)
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + PRESC_W'(1);

      if (wr_count)
        count <= wr_data;
      else if (wrap)
        count <= '0;
      else if (tick)
        count <= count + 16'd1;

      if (wrap)
        flag <= 1'b1;
      else if (wr_status && wr_data[0])
        flag <= 1'b0;

      if (wr_ctrl) begin
        en      <= wr_data[CTRL_EN];
        oneshot <= wr_data[CTRL_ONESHOT];
        irq_en  <= wr_data[CTRL_IRQ_EN];
        presc   <= wr_data[CTRL_PRESC_LSB +: PRESC_W];
      end else if (wrap && oneshot) begin
        en <= 1'b0;
      end

      if (wr_max)
        max_val <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_EN]                      = en;
        rd_data[CTRL_ONESHOT]                 = oneshot;
        rd_data[CTRL_IRQ_EN]                  = irq_en;
        rd_data[CTRL_PRESC_LSB +: PRESC_W]    = presc;
      end
      REG_COUNT:  rd_data = count;
      REG_MAX:    rd_data = max_val;
      REG_STATUS: rd_data[0] = flag;
      default:    rd_data = '0;
    endcase
  end

  assign irq = flag && irq_en;

endmodule

// File: rtl/mapped_timer_bank.sv
// Bank of NUM_CH memory-mapped timer channels: window decode, channel
// instances, combinational read mux and interrupt OR.
module mapped_timer_bank
  import mapped_timer_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter logic [13:0] BASE_ADDR = 14'h0010,
  parameter int          PRESC_W   = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [13:0]  i_memAddr,
  input  logic [15:0]  i_memDataIn,
  input  logic         i_memWrEn,
  output logic [15:0]  o_memDataOut,
  output logic         o_irq
);

  localparam logic [14:0] WIN_END = {1'b0, BASE_ADDR} + 15'(4 * NUM_CH);

  logic [13:0] offset;
  logic [11:0] ch_sel;
  logic [1:0]  reg_sel;
  logic        hit;

  logic [15:0]       rd_data [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;

  // BASE_ADDR is window-aligned, so the offset's low bits equal the address's.
  assign offset  = i_memAddr - BASE_ADDR;
  assign ch_sel  = offset[13:2];
  assign reg_sel = offset[1:0];
  assign hit     = (i_memAddr >= BASE_ADDR) && ({1'b0, i_memAddr} < WIN_END);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mapped_timer_ch #(
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk     (i_clk),
      .rst     (i_rst),
      .reg_sel (reg_sel),
      .wr_data (i_memDataIn),
      .wr_en   (i_memWrEn && hit && (ch_sel == 12'(i))),
      .rd_data (rd_data[i]),
      .irq     (irq_vec[i])
    );
  end

  always_comb begin
    o_memDataOut = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit && (ch_sel == 12'(i)))
        o_memDataOut = rd_data[i];
    end
  end

  assign o_irq = |irq_vec;

endmodule

// File: tb/tb_mapped_timer_bank.sv
// Scoreboard bench for mapped_timer_bank: a default 2-channel bank and a
// 4-channel bank at 0x0040 share one bus.
module tb_mapped_timer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic        wr_en;
  logic        rd_req;
  logic [15:0] data1, data2;
  logic        irq1, irq2;

  always #5 clk = ~clk;

  mapped_timer_bank #(.NUM_CH(2), .BASE_ADDR(14'h0010), .PRESC_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memDataIn(wdata),
    .i_memWrEn(wr_en), .o_memDataOut(data1), .o_irq(irq1));

  mapped_timer_bank #(.NUM_CH(4), .BASE_ADDR(14'h0040), .PRESC_W(8)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memDataIn(wdata),
    .i_memWrEn(wr_en), .o_memDataOut(data2), .o_irq(irq2));

  // src: 0 dut1 data, 1 dut1 irq, 2 dut2 data, 3 dut2 irq
  typedef struct {
    int          src;
    logic [15:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  always @(negedge clk) begin
    if (rd_req) begin
      while (sb.size() > 0) begin
        sb_item_t it;
        logic [15:0] act;
        it = sb.pop_front();
        case (it.src)
          0:       act = data1;
          1:       act = {15'd0, irq1};
          2:       act = data2;
          default: act = {15'd0, irq2};
        endcase
        n_chk++;
        if (act === it.exp)
          n_pass++;
        else
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic push(input int src, input logic [15:0] e, input string nm);
    sb_item_t it;
    it.src  = src;
    it.exp  = e;
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input int src, input logic [13:0] a, input logic [15:0] e, input string nm);
    addr = a;
    push(src, e, nm);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic rd_irq(input logic [13:0] a, input logic [15:0] e, input logic ei, input string nm);
    addr = a;
    push(0, e, nm);
    push(1, {15'd0, ei}, {nm, "_irq"});
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    addr   = '0;
    wdata  = '0;
    wr_en  = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state of both banks
    for (int a = 0; a < 8; a++)
      rd(0, 14'h0010 + 14'(a), (a % 4 == 2) ? 16'hFFFF : 16'h0000, $sformatf("rst1_%0d", a));
    for (int a = 0; a < 16; a++)
      rd(2, 14'h0040 + 14'(a), (a % 4 == 2) ? 16'hFFFF : 16'h0000, $sformatf("rst2_%0d", a));
    addr = 14'h0000;
    push(0, 16'h0000, "miss0_1");
    push(2, 16'h0000, "miss0_2");
    push(1, 16'h0000, "rst_irq1");
    rd(3, 14'h0000, 16'h0000, "rst_irq2");

    // ch0 periodic, PRESC=2: count steps every 3 cycles, wraps 12 cycles in
    wr(14'h0012, 16'd3);
    wr(14'h0010, 16'h0205);
    for (int i = 0; i <= 12; i++)
      rd_irq(14'h0011, (i == 12) ? 16'd0 : 16'(i / 3), (i >= 12), $sformatf("per_cnt_%0d", i));
    rd(0, 14'h0013, 16'h0001, "per_flag");

    // W1C clear, then clear coinciding with the next wrap
    wr(14'h0013, 16'h0001);
    rd_irq(14'h0013, 16'h0000, 1'b0, "w1c_clear");
    idle(7);
    wr(14'h0013, 16'h0001);
    rd_irq(14'h0013, 16'h0001, 1'b1, "w1c_vs_set");

    // COUNT write colliding with a tick, PRESC=0
    wr(14'h0010, 16'h0000);
    wr(14'h0012, 16'hFFFF);
    wr(14'h0011, 16'd5);
    rd_irq(14'h0011, 16'd5, 1'b0, "hold_dis");
    wr(14'h0010, 16'h0001);
    wr(14'h0011, 16'h0100);
    rd(0, 14'h0011, 16'h0100, "cnt_wr_0");
    rd(0, 14'h0011, 16'h0101, "cnt_wr_1");
    rd(0, 14'h0011, 16'h0102, "cnt_wr_2");

    // ch1 one-shot, MAX=1, IRQ_EN=0
    wr(14'h0016, 16'd1);
    wr(14'h0014, 16'h0003);
    rd_irq(14'h0015, 16'd0, 1'b0, "os_cnt_0");
    rd_irq(14'h0015, 16'd1, 1'b0, "os_cnt_1");
    rd_irq(14'h0017, 16'd1, 1'b0, "os_flag");
    rd(0, 14'h0014, 16'h0002, "os_ctrl");
    rd(0, 14'h0015, 16'h0000, "os_cnt_hold_a");
    rd(0, 14'h0015, 16'h0000, "os_cnt_hold_b");

    // reset mid-count
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_irq(14'h0010, 16'h0000, 1'b0, "mid_rst_ctrl");
    rd(0, 14'h0011, 16'h0000, "mid_rst_cnt0");
    rd(0, 14'h0011, 16'h0000, "mid_rst_cnt1");
    rd(0, 14'h0012, 16'hFFFF, "mid_rst_max");
    rd(0, 14'h0017, 16'h0000, "mid_rst_flag1");

    // 4-channel bank at 0x0040: decode edges
    wr(14'h004E, 16'h00AA);
    rd(2, 14'h004E, 16'h00AA, "sw_max3");
    wr(14'h0050, 16'h1234);
    wr(14'h003F, 16'h5678);
    rd(2, 14'h0050, 16'h0000, "sw_miss_hi");
    rd(2, 14'h003F, 16'h0000, "sw_miss_lo");
    rd(0, 14'h003F, 16'h0000, "sw_miss_lo_b1");
    for (int a = 0; a < 16; a++)
      rd(2, 14'h0040 + 14'(a),
         (a == 14) ? 16'h00AA : ((a % 4 == 2) ? 16'hFFFF : 16'h0000),
         $sformatf("sw_after_%0d", a));
    rd(3, 14'h0040, 16'h0000, "sw_irq");

    idle(2);
    n_chk++;
    if (sb.size() == 0)
      n_pass++;
    else
      $display("FAIL sb_drain: got %0d left expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
